// File: rtl/seq_multiplier_32.sv
// ============================================================================
//  Module   : seq_multiplier_32
//  Purpose  : Iterative shift-add RV32M multiplier; full 2*WIDTH product.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_multiplier_32 #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               rdy,
   output logic [2*WIDTH-1:0] mul_out
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     mul_out_q, mul_out_d;

   logic              a_neg, b_neg;
   logic [WIDTH-1:0]  a_mag, b_mag;

   // op 11 is the only unsigned-a encoding; b is signed only for 00/01.
   assign a_neg = (op != 2'b11) && multiplicand[WIDTH-1];
   assign b_neg = (op[1] == 1'b0) && multiplier[WIDTH-1];
   assign a_mag = a_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
   assign b_mag = b_neg ? (~multiplier + WIDTH'(1)) : multiplier;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      neg_d     = neg_q;
      mul_out_d = mul_out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = a_neg ^ b_neg;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            mul_out_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
            state_d   = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         neg_q     <= 1'b0;
         mul_out_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         neg_q     <= neg_d;
         mul_out_q <= mul_out_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign rdy     = (state_q == S_DONE);
   assign mul_out = mul_out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_32.sv
// ============================================================================
//  Module   : tb_seq_multiplier_32
//  Purpose  : Directed self-checking bench for seq_multiplier_32.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier_32;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        rdy;
   logic [63:0] mul_out;

   int n_checks = 0;
   int n_fails  = 0;

   seq_multiplier_32 #(.WIDTH(32)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .multiplicand (a),
      .multiplier   (b),
      .busy         (busy),
      .rdy          (rdy),
      .mul_out      (mul_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Counts edges after the accept edge until rdy; optionally scrambles inputs.
   task automatic wait_rdy(input bit scramble, output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (scramble) begin
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
         end
         if (rdy) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
      int lat;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, " busy"}, 64'(busy), 64'd1);
      wait_rdy(1'b1, lat);
      check_eq({tag, " lat"}, 64'(lat), 64'd33);
      check_eq({tag, " prod"}, mul_out, exp);
      @(negedge clk);
      check_eq({tag, " rdy_pulse"}, 64'({rdy, busy}), 64'd0);
   endtask

   initial begin
      int lat;
      int rdy_seen;

      repeat (2) @(negedge clk);
      check_eq("rst busy", 64'(busy), 64'd0);
      check_eq("rst rdy", 64'(rdy), 64'd0);
      check_eq("rst out", mul_out, 64'd0);
      reset = 1'b1;

      run_op("u7x6",      2'b11, 32'd7,          32'd6,          64'h0000_0000_0000_002A);
      run_op("sm7x6",     2'b01, 32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6);
      run_op("s_min2",    2'b01, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
      run_op("u_min2",    2'b11, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
      run_op("su_min2",   2'b10, 32'h8000_0000,  32'h8000_0000,  64'hC000_0000_0000_0000);
      run_op("su_ones",   2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_0000_0001);
      run_op("u_ones",    2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
      run_op("s_ones",    2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);
      run_op("s_zero",    2'b00, 32'd0,          32'hFFFF_FFFF,  64'h0000_0000_0000_0000);
      run_op("s_m5m3",    2'b01, 32'hFFFF_FFFB,  32'hFFFF_FFFD,  64'h0000_0000_0000_000F);
      run_op("u_shift",   2'b11, 32'h1234_5678,  32'h0000_0010,  64'h0000_0001_2345_6780);

      // start held high: operands change after accept, second request follows DONE
      @(negedge clk);
      op = 2'b11; a = 32'd7; b = 32'd6; start = 1'b1;
      @(negedge clk);
      op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      wait_rdy(1'b0, lat);
      check_eq("b2b lat1", 64'(lat), 64'd33);
      check_eq("b2b prod1", mul_out, 64'h0000_0000_0000_002A);
      @(negedge clk);
      check_eq("b2b idle", 64'({rdy, busy}), 64'd0);
      @(negedge clk);
      check_eq("b2b accept", 64'(busy), 64'd1);
      check_eq("b2b hold", mul_out, 64'h0000_0000_0000_002A);
      start = 1'b0;
      wait_rdy(1'b0, lat);
      check_eq("b2b lat2", 64'(lat), 64'd33);
      check_eq("b2b prod2", mul_out, 64'h0000_0000_0000_0001);

      // reset mid-operation on a 7x6 product
      @(negedge clk);
      op = 2'b11; a = 32'd7; b = 32'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("abort busy", 64'(busy), 64'd0);
      check_eq("abort rdy", 64'(rdy), 64'd0);
      check_eq("abort out", mul_out, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rdy) rdy_seen++;
      end
      check_eq("abort no_rdy", 64'(rdy_seen), 64'd0);
      run_op("post_rst", 2'b11, 32'd7, 32'd6, 64'h0000_0000_0000_002A);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_multiplier_32.md
Name: seq_multiplier_32

Overview:
- Iterative shift-add multiplier for the RV32M unit; the multiply counterpart of the sequential divider.
- Accepts two 32-bit operands with a signedness select and produces the full 64-bit product in 33 cycles, using the same start/rdy handshake style as the divider.
- The execute stage picks the low word for MUL and the high word for MULH/MULHSU/MULHU.

Parameters:
WIDTH, 32, operand width. Product is 2*WIDTH. Only 32 is verified.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  00/01 signed x signed, 10 signed(a) x unsigned(b), 11 unsigned x unsigned
multiplicand  input  32  operand a (rs1), sampled with start
multiplier  input  32  operand b (rs2), sampled with start
busy  output  1  high from accept until rdy cycle inclusive
rdy  output  1  one-cycle pulse, mul_out valid
mul_out  output  64  product; held until next accepted start

Behaviour:
Reset:
- reset low: state=IDLE, counter=0, internal accumulator/operand registers=0.
- Outputs: busy=0, rdy=0, mul_out=0.
- Reset asserted mid-operation aborts the operation immediately; no rdy is produced.

FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with start=1: latch |a| and |b| per op signedness. An operand is negative only if it is signed and bit31=1.
  - Latch neg_sign = sign_a XOR sign_b.
  - Clear the 64-bit accumulator and the 5-bit counter; go to RUN.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - If multiplier LSB=1, add the 64-bit shifted multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; counter+1.
  - On the edge where counter==31 (32nd iteration), go to FIX.
- FIX:
  - mul_out <= neg_sign ? two's-complement(accumulator) : accumulator, with 64-bit negation and carry across both words.
  - Go to DONE.
- DONE:
  - rdy=1 and busy=1 for exactly this cycle.
  - Next edge: go to IDLE.
  - A start seen on this edge is ignored; a new request is accepted only in IDLE.

Outputs and width rules:
- busy=1 in RUN, FIX and DONE; otherwise 0.
- rdy is registered (Moore output of DONE). It must never be high in two consecutive cycles.
- Latency: accept edge E0, iterations E1..E32, FIX writes mul_out on E33, rdy high in the cycle following E33. Total 33 edges from accept to rdy.
- Magnitude of 0x80000000 in a signed operand is 2^31 and fits unsigned 32-bit; no overflow.
- The accumulator is 64-bit and unsigned. The unsigned product of two 32-bit magnitudes cannot overflow 64 bits.
- A zero operand runs the full 32 iterations (no early exit). Result is 0; neg_sign is irrelevant because -0 = 0.
- start, op and operands are ignored while busy. Operand changes after accept must not affect the result.
- mul_out changes only on the FIX edge and on reset.

Test Plan:
- op=11, a=7, b=6; pulse start one cycle -> busy rises next cycle; rdy pulses exactly 33 edges after accept; mul_out=64'h0000_0000_0000_002A.
- op=01, a=0xFFFF_FFF9 (-7), b=6 -> mul_out=64'hFFFF_FFFF_FFFF_FFD6.
- op=01, a=b=0x8000_0000 -> mul_out=64'h4000_0000_0000_0000. Same operands with op=11 -> 64'h4000_0000_0000_0000. With op=10 -> 64'hC000_0000_0000_0000.
- a=b=0xFFFF_FFFF: op=10 -> 64'hFFFF_FFFF_0000_0001; op=11 -> 64'hFFFF_FFFE_0000_0001; op=00 -> 64'h0000_0000_0000_0001.
- Start held high continuously with operands changed mid-run -> first result is correct for the originally latched values; rdy is a single-cycle pulse; the next accept happens on the edge after DONE (IDLE); back-to-back results are both correct.
- Drive reset low at iteration 10 of a 7x6 op -> busy=0, rdy=0, mul_out=0 immediately. No rdy is produced afterward. A new request after release completes normally in 33 edges.
